hv_fold_distance_engine: RTL and testbench
==========================================

# hv_fold_distance_engine

Fold-serial Hamming-distance engine for the folded associative-memory path. Accepts one query hypervector and one class hypervector per transaction and XORs them. Walks the difference vector one fold per cycle through the per-fold popcount adder and accumulates a full-vector distance. Returns the distance to the classifier's argmin stage over a valid/ready handshake.

## Interface
- NUM_FOLDS, 8, number of folds per hypervector (≥1)
- NUM_FOLDS_WIDTH, 3, width of fold index, ≥ clog2(NUM_FOLDS), min 1
- FOLD_WIDTH, 250, bits per fold; full vector is NUM_FOLDS*FOLD_WIDTH (2000 default)
- `DISTANCE_WIDTH (const.vh), 11, distance width; must satisfy 2^`DISTANCE_WIDTH > NUM_FOLDS*FOLD_WIDTH
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- hv_valid  input  1  query_hv/class_hv valid
- hv_ready  output  1  engine can accept a vector pair
- query_hv  input  NUM_FOLDS*FOLD_WIDTH  query hypervector
- class_hv  input  NUM_FOLDS*FOLD_WIDTH  class (AM) hypervector
- distance_valid  output  1  distance holds a completed result
- distance_ready  input  1  downstream accepts distance
- distance  output  `DISTANCE_WIDTH  Hamming distance of the accepted pair

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: hv_ready=1. On hv_valid&&hv_ready: latch diff = query_hv ^ class_hv, fold_idx←0, acc←0, go ACCUM.
- ACCUM: hv_ready=0. Each cycle: acc ← acc + popcount(diff fold fold_idx), fold_idx ← fold_idx+1. Fold k = diff[k*FOLD_WIDTH +: FOLD_WIDTH]; fold 0 first.
- When fold_idx==NUM_FOLDS-1, the final add is written to acc and the FSM goes to DONE. NUM_FOLDS=1 makes ACCUM exactly one cycle.
- DONE: distance_valid=1, distance=acc, held stable. On distance_ready go IDLE. No acceptance in DONE.
- Arithmetic: unsigned, `DISTANCE_WIDTH wide, no saturation; the parameter constraint guarantees no overflow.
- Inputs are ignored outside IDLE. hv_valid does not need to stay high after the handshake.
- Reset, including mid-ACCUM or mid-DONE: state IDLE, acc=0, fold_idx=0, diff=0. Any in-flight result is discarded and no distance_valid is emitted for it.

## Timing
- Reset values: hv_ready=1 (IDLE), distance_valid=0, distance=0.
- hv_ready and distance_valid are decoded from state only. No combinational path from distance_ready or hv_valid to any output.
- Handshake captured at edge T → ACCUM for cycles T..T+NUM_FOLDS-1 → distance_valid=1 after edge T+NUM_FOLDS.
- Latency: NUM_FOLDS+1 edges from input handshake to distance_valid. With distance_ready held high, DONE lasts 1 cycle.
- Minimum initiation interval: NUM_FOLDS+2 cycles (default 10).
- Back-pressure: distance and distance_valid stay constant while distance_ready=0, for any duration.
- The per-fold popcount is combinational within one cycle. The only register on the popcount→acc path is acc itself.

## Structure
- Shared package/const.vh: `DISTANCE_WIDTH, default NUM_FOLDS/FOLD_WIDTH/NUM_FOLDS_WIDTH values, and an FSM state enum (IDLE/ACCUM/DONE) for use by the argmin controller.
- One sub-module: the existing hv_binary_adder, instantiated once on the selected fold with the same NUM_FOLDS/NUM_FOLDS_WIDTH/FOLD_WIDTH. Its distance output feeds the accumulator.
- Fold select is an indexed part-select on diff by fold_idx. No per-fold adder replication.

## Test plan
- query_hv = class_hv = random → distance=0, distance_valid after exactly 9 edges (defaults).
- query_hv = all 0, class_hv = all 1 → distance=2000.
- Only bit 1999 differs (last fold, top bit) → distance=1. Only bit 0 differs → distance=1.
- Three back-to-back pairs, distance_ready held low 5 cycles on the second result → distance stable for 6 cycles, hv_ready=0 throughout. Results in order: 0, 2000, 1000 (alternating-bit pattern).
- rst pulsed for 1 cycle at ACCUM cycle 4 → next cycle hv_ready=1, distance_valid=0, distance=0. The subsequent all-ones-difference pair yields 2000.
- NUM_FOLDS=1, FOLD_WIDTH=16, diff=16'h00FF → distance=8, valid 2 edges after the handshake.

Source files
------------

// File: rtl/hv_fold_distance_engine_pkg.sv
// Shared widths, default fold geometry and the engine FSM state type.
// The argmin controller reuses the state type.
package hv_fold_distance_engine_pkg;

  localparam int unsigned DISTANCE_WIDTH          = 11;
  localparam int unsigned NUM_FOLDS_DEFAULT       = 8;
  localparam int unsigned NUM_FOLDS_WIDTH_DEFAULT = 3;
  localparam int unsigned FOLD_WIDTH_DEFAULT      = 250;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } fold_state_e;

endpackage

// File: rtl/hv_fold_distance_engine_adder.sv
// Combinational popcount of one fold of the difference vector.
// There is a single instance, which is shared by every fold.
module hv_binary_adder
  import hv_fold_distance_engine_pkg::*;
#(
  parameter int unsigned NUM_FOLDS       = NUM_FOLDS_DEFAULT,
  parameter int unsigned NUM_FOLDS_WIDTH = NUM_FOLDS_WIDTH_DEFAULT,
  parameter int unsigned FOLD_WIDTH      = FOLD_WIDTH_DEFAULT
) (
  input  logic [FOLD_WIDTH-1:0]     i_fold,
  output logic [DISTANCE_WIDTH-1:0] o_distance
);

  if (NUM_FOLDS < 1 || NUM_FOLDS_WIDTH < 1 || (2 ** DISTANCE_WIDTH) <= NUM_FOLDS * FOLD_WIDTH)
  begin : g_bad_geometry
    $error("hv_binary_adder: unsupported fold geometry");
  end

  logic [DISTANCE_WIDTH-1:0] w_count;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < FOLD_WIDTH; i++) begin
      w_count = w_count + DISTANCE_WIDTH'(i_fold[i]);
    end
  end

  assign o_distance = w_count;

endmodule

// File: rtl/hv_fold_distance_engine.sv
// Fold-serial Hamming distance: latch query^class, then add one fold popcount per cycle.
// The result is held in DONE until the argmin stage accepts it.
module hv_fold_distance_engine
  import hv_fold_distance_engine_pkg::*;
#(
  parameter int unsigned NUM_FOLDS       = NUM_FOLDS_DEFAULT,
  parameter int unsigned NUM_FOLDS_WIDTH = NUM_FOLDS_WIDTH_DEFAULT,
  parameter int unsigned FOLD_WIDTH      = FOLD_WIDTH_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            hv_valid,
  output logic                            hv_ready,
  input  logic [NUM_FOLDS*FOLD_WIDTH-1:0] query_hv,
  input  logic [NUM_FOLDS*FOLD_WIDTH-1:0] class_hv,
  output logic                            distance_valid,
  input  logic                            distance_ready,
  output logic [DISTANCE_WIDTH-1:0]       distance
);

  localparam int unsigned VecWidth = NUM_FOLDS * FOLD_WIDTH;

  fold_state_e                r_state, w_state_d;
  logic [VecWidth-1:0]        r_diff, w_diff_d;
  logic [NUM_FOLDS_WIDTH-1:0] r_fold_idx, w_fold_idx_d;
  logic [DISTANCE_WIDTH-1:0]  r_acc, w_acc_d;
  logic [FOLD_WIDTH-1:0]      w_fold;
  logic [DISTANCE_WIDTH-1:0]  w_fold_count;

  assign w_fold = r_diff[r_fold_idx * FOLD_WIDTH +: FOLD_WIDTH];

  hv_binary_adder #(
    .NUM_FOLDS       (NUM_FOLDS),
    .NUM_FOLDS_WIDTH (NUM_FOLDS_WIDTH),
    .FOLD_WIDTH      (FOLD_WIDTH)
  ) u_adder (
    .i_fold     (w_fold),
    .o_distance (w_fold_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_diff     <= '0;
      r_fold_idx <= '0;
      r_acc      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_diff     <= w_diff_d;
      r_fold_idx <= w_fold_idx_d;
      r_acc      <= w_acc_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_diff_d     = r_diff;
    w_fold_idx_d = r_fold_idx;
    w_acc_d      = r_acc;
    unique case (r_state)
      StIdle: begin
        if (hv_valid) begin
          w_diff_d     = query_hv ^ class_hv;
          w_fold_idx_d = '0;
          w_acc_d      = '0;
          w_state_d    = StAccum;
        end
      end
      StAccum: begin
        w_acc_d      = r_acc + w_fold_count;
        w_fold_idx_d = r_fold_idx + NUM_FOLDS_WIDTH'(1);
        if (r_fold_idx == NUM_FOLDS_WIDTH'(NUM_FOLDS - 1)) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        if (distance_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs come from registers only, never from the input handshakes.
  assign hv_ready       = (r_state == StIdle);
  assign distance_valid = (r_state == StDone);
  assign distance       = r_acc;

endmodule

// File: tb/tb_hv_fold_distance_engine.sv
// Directed bench for hv_fold_distance_engine (default geometry plus a one-fold instance).
// Expected distances are queued at send time and compared on distance_valid.
module tb_hv_fold_distance_engine;

  localparam int W  = 2000;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          hv_valid, hv_ready, distance_valid, distance_ready;
  logic [W-1:0]  query_hv, class_hv;
  logic [10:0]   distance;
  logic          s_hv_valid, s_hv_ready, s_distance_valid, s_distance_ready;
  logic [SW-1:0] s_query, s_class;
  logic [10:0]   s_distance;

  int n_vec = 0;
  int n_err = 0;
  int sb[$];

  always #5 clk = ~clk;

  hv_fold_distance_engine u_dut (
    .clk            (clk),
    .rst            (rst),
    .hv_valid       (hv_valid),
    .hv_ready       (hv_ready),
    .query_hv       (query_hv),
    .class_hv       (class_hv),
    .distance_valid (distance_valid),
    .distance_ready (distance_ready),
    .distance       (distance)
  );

  hv_fold_distance_engine #(
    .NUM_FOLDS       (1),
    .NUM_FOLDS_WIDTH (1),
    .FOLD_WIDTH      (SW)
  ) u_small (
    .clk            (clk),
    .rst            (rst),
    .hv_valid       (s_hv_valid),
    .hv_ready       (s_hv_ready),
    .query_hv       (s_query),
    .class_hv       (s_class),
    .distance_valid (s_distance_valid),
    .distance_ready (s_distance_ready),
    .distance       (s_distance)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < W; i += 32) v[i +: 32] = $urandom();
    return v;
  endfunction

  task automatic send(input logic [W-1:0] q, input logic [W-1:0] c, input bit push);
    for (int i = 0; i < 30 && !hv_ready; i++) step();
    check("hv_ready_before_send", 32'(hv_ready), 32'd1);
    query_hv = q;
    class_hv = c;
    hv_valid = 1'b1;
    if (push) sb.push_back($countones(q ^ c));
    step();
    hv_valid = 1'b0;
    // Scramble inputs to show they are ignored once the pair is latched.
    query_hv = rand_vec();
    class_hv = rand_vec();
  endtask

  task automatic collect(input int hold);
    int edges;
    int exp;
    edges = 1;
    while (!distance_valid && edges < 50) begin
      step();
      edges++;
    end
    check("latency_edges", 32'(edges), 32'd9);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
      exp = 0;
    end else begin
      exp = sb.pop_front();
    end
    for (int i = 0; i <= hold; i++) begin
      check("distance", 32'(distance), 32'(exp));
      check("distance_valid_held", 32'(distance_valid), 32'd1);
      check("hv_ready_low_in_done", 32'(hv_ready), 32'd0);
      if (i < hold) step();
    end
    distance_ready = 1'b1;
    step();
    distance_ready = 1'b0;
    check("valid_drop_after_accept", 32'(distance_valid), 32'd0);
    check("hv_ready_after_accept", 32'(hv_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] alt;
    int edges;

    rst = 1'b1;
    hv_valid = 1'b0;
    distance_ready = 1'b0;
    query_hv = '0;
    class_hv = '0;
    s_hv_valid = 1'b0;
    s_distance_ready = 1'b0;
    s_query = '0;
    s_class = '0;
    step();
    step();
    check("reset_hv_ready", 32'(hv_ready), 32'd1);
    check("reset_distance_valid", 32'(distance_valid), 32'd0);
    check("reset_distance", 32'(distance), 32'd0);
    rst = 1'b0;

    // Identical vectors.
    v = rand_vec();
    send(v, v, 1'b1);
    collect(0);

    // Every bit differs.
    send('0, '1, 1'b1);
    collect(0);

    // Single-bit differences at the top of the last fold and bottom of fold 0.
    v = '0;
    v[W-1] = 1'b1;
    send(v, '0, 1'b1);
    collect(0);
    v = '0;
    v[0] = 1'b1;
    send('0, v, 1'b1);
    collect(0);

    // Back-to-back pairs with back-pressure on the second result.
    for (int i = 0; i < W; i += 2) alt[i +: 2] = 2'b01;
    send(v, v, 1'b1);
    collect(0);
    send('0, '1, 1'b1);
    collect(5);
    send(alt, '0, 1'b1);
    collect(0);

    // Reset in ACCUM cycle 4 drops the in-flight result.
    send('1, '0, 1'b0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset_hv_ready", 32'(hv_ready), 32'd1);
    check("midreset_distance_valid", 32'(distance_valid), 32'd0);
    check("midreset_distance", 32'(distance), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("no_valid_after_reset", 32'(distance_valid), 32'd0);
      step();
    end
    send('1, '0, 1'b1);
    collect(0);

    // Random pairs against the popcount model.
    for (int k = 0; k < 3; k++) begin
      send(rand_vec(), rand_vec(), 1'b1);
      collect(k);
    end

    // One-fold instance: ACCUM lasts exactly one cycle.
    check("small_reset_ready", 32'(s_hv_ready), 32'd1);
    s_query = 16'h00FF;
    s_class = 16'h0000;
    s_hv_valid = 1'b1;
    step();
    s_hv_valid = 1'b0;
    s_query = 16'hA5A5;
    edges = 1;
    while (!s_distance_valid && edges < 20) begin
      step();
      edges++;
    end
    check("small_latency_edges", 32'(edges), 32'd2);
    check("small_distance", 32'(s_distance), 32'd8);
    s_distance_ready = 1'b1;
    step();
    s_distance_ready = 1'b0;
    check("small_ready_after_accept", 32'(s_hv_ready), 32'd1);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
